// File: rtl/eth_type_demux.sv
// rtl/eth_type_demux.sv - Routes Ethernet frames to one of M_COUNT outputs by ethertype; unmatched frames are dropped and counted.
module eth_type_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_eth_hdr_valid,
    output logic                    s_eth_hdr_ready,
    input  logic [47:0]             s_eth_dest_mac,
    input  logic [47:0]             s_eth_src_mac,
    input  logic [15:0]             s_eth_type,
    input  logic [DATA_WIDTH-1:0]   s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_eth_payload_axis_tkeep,
    input  logic                    s_eth_payload_axis_tvalid,
    output logic                    s_eth_payload_axis_tready,
    input  logic                    s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_eth_payload_axis_tuser,
    output logic [M_COUNT-1:0]      m_eth_hdr_valid,
    input  logic [M_COUNT-1:0]      m_eth_hdr_ready,
    output logic [47:0]             m_eth_dest_mac,
    output logic [47:0]             m_eth_src_mac,
    output logic [15:0]             m_eth_type,
    output logic [DATA_WIDTH-1:0]   m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_eth_payload_axis_tkeep,
    output logic [M_COUNT-1:0]      m_eth_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]      m_eth_payload_axis_tready,
    output logic                    m_eth_payload_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_eth_payload_axis_tuser,
    input  logic [M_COUNT*16-1:0]   match_type,
    input  logic [M_COUNT-1:0]      match_enable,
    output logic [COUNT_WIDTH-1:0]  drop_count,
    output logic                    busy
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [47:0]             dest_q, dest_d;
    logic [47:0]             src_q, src_d;
    logic [15:0]             type_q, type_d;
    logic [COUNT_WIDTH-1:0]  drop_q, drop_d;

    logic                    match_found;
    logic [SEL_W-1:0]        match_idx;

    // Scanning downward lets the lowest matching index win on duplicates.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (match_enable[i] && (match_type[16*i +: 16] == s_eth_type)) begin
                match_found = 1'b1;
                match_idx   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            type_q  <= type_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d                   = state_q;
        sel_d                     = sel_q;
        dest_d                    = dest_q;
        src_d                     = src_q;
        type_d                    = type_q;
        drop_d                    = drop_q;
        s_eth_hdr_ready           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        m_eth_hdr_valid           = '0;
        m_eth_payload_axis_tvalid = '0;

        case (state_q)
            ST_IDLE: begin
                s_eth_hdr_ready = 1'b1;
                if (s_eth_hdr_valid) begin
                    if (match_found) begin
                        state_d = ST_HDR;
                        sel_d   = match_idx;
                        dest_d  = s_eth_dest_mac;
                        src_d   = s_eth_src_mac;
                        type_d  = s_eth_type;
                    end else begin
                        state_d = ST_DROP;
                        if (drop_q != '1) begin
                            drop_d = drop_q + COUNT_WIDTH'(1);
                        end
                    end
                end
            end
            ST_HDR: begin
                m_eth_hdr_valid[sel_q] = 1'b1;
                if (m_eth_hdr_ready[sel_q]) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                m_eth_payload_axis_tvalid[sel_q] = s_eth_payload_axis_tvalid;
                s_eth_payload_axis_tready        = m_eth_payload_axis_tready[sel_q];
                if (s_eth_payload_axis_tvalid && m_eth_payload_axis_tready[sel_q]
                        && s_eth_payload_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_eth_payload_axis_tready = 1'b1;
                if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are forced quiet in the reset cycle itself.
        if (rst) begin
            s_eth_hdr_ready           = 1'b0;
            s_eth_payload_axis_tready = 1'b0;
            m_eth_hdr_valid           = '0;
            m_eth_payload_axis_tvalid = '0;
        end
    end

    assign m_eth_dest_mac           = dest_q;
    assign m_eth_src_mac            = src_q;
    assign m_eth_type               = type_q;
    assign m_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
    assign m_eth_payload_axis_tkeep = (KEEP_ENABLE != 0) ? s_eth_payload_axis_tkeep
                                                         : {KEEP_WIDTH{1'b1}};
    assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
    assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;
    assign drop_count               = drop_q;
    assign busy                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_type_demux.sv
// tb/tb_eth_type_demux.sv - Randomized self-checking bench for eth_type_demux against a frame-level routing model.
module tb_eth_type_demux;

    localparam int M  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_eth_hdr_valid;
    logic              s_eth_hdr_ready;
    logic [47:0]       s_eth_dest_mac;
    logic [47:0]       s_eth_src_mac;
    logic [15:0]       s_eth_type;
    logic [DW-1:0]     s_tdata;
    logic [KW-1:0]     s_tkeep;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [UW-1:0]     s_tuser;
    logic [M-1:0]      m_eth_hdr_valid;
    logic [M-1:0]      m_eth_hdr_ready;
    logic [47:0]       m_eth_dest_mac;
    logic [47:0]       m_eth_src_mac;
    logic [15:0]       m_eth_type;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [M-1:0]      m_tvalid;
    logic [M-1:0]      m_tready;
    logic              m_tlast;
    logic [UW-1:0]     m_tuser;
    logic [M*16-1:0]   match_type;
    logic [M-1:0]      match_enable;
    logic [CW-1:0]     drop_count;
    logic              busy;

    always #5 clk = ~clk;

    eth_type_demux #(
        .M_COUNT(M), .DATA_WIDTH(DW), .KEEP_ENABLE(0), .KEEP_WIDTH(KW),
        .USER_WIDTH(UW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
        .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
        .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
        .match_type(match_type), .match_enable(match_enable),
        .drop_count(drop_count), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] tbl [M];
    logic [M-1:0] en;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int exp_drops = 0;

    int rmode = 0;
    int hdr_delay = 0;
    int hv_cnt = 0;
    bit tog = 1'b0;

    always_comb begin
        match_type = '0;
        for (int i = 0; i < M; i++) match_type[16*i +: 16] = tbl[i];
    end
    assign match_enable = en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference routing rule: first enabled entry whose ethertype matches, else drop.
    function automatic int route(input logic [15:0] t);
        for (int i = 0; i < M; i++) if (en[i] && tbl[i] == t) return i;
        return -1;
    endfunction

    function automatic logic [M-1:0] onehot(input int p);
        logic [M-1:0] r;
        r = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] pack(input int p, input logic [DW-1:0] d,
                                         input logic l, input logic [UW-1:0] u);
        return {32'(p), 16'(d), 8'(l), 8'(u)};
    endfunction

    function automatic logic [15:0] pick_type();
        case ($urandom_range(4))
            0: return 16'h0800;
            1: return 16'h0806;
            2: return 16'h86DD;
            3: return 16'h88F7;
            default: return 16'h1234;
        endcase
    endfunction

    // Sink: header ready after hdr_delay cycles of valid; payload ready per rmode.
    always @(posedge clk) begin
        #1;
        if (m_eth_hdr_valid != '0) begin
            m_eth_hdr_ready = (hv_cnt >= hdr_delay) ? '1 : '0;
            hv_cnt++;
        end else begin
            m_eth_hdr_ready = M'($urandom);
            hv_cnt = 0;
        end
        tog = ~tog;
        case (rmode)
            0: m_tready = '1;
            1: m_tready = M'($urandom);
            default: m_tready = tog ? '1 : '0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("hv_onehot", 64'($countones(m_eth_hdr_valid) <= 1), 1);
            check("tv_onehot", 64'($countones(m_tvalid) <= 1), 1);
            for (int p = 0; p < M; p++) begin
                if (m_tvalid[p] && m_tready[p]) begin
                    got_q.push_back(pack(p, m_tdata, m_tlast, m_tuser));
                    check("tkeep_ones", m_tkeep, 1);
                end
            end
        end
    end

    task automatic compare_q();
        check("beat_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) check("beat", got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
        check("drop_count", drop_count, exp_drops);
    endtask

    task automatic set_beat(input int i, input int nbeats);
        s_tdata = DW'($urandom);
        s_tkeep = KW'($urandom);
        s_tlast = (i == nbeats - 1);
        s_tuser = UW'($urandom);
    endtask

    task automatic send_frame(input logic [15:0] t, input int nbeats, input int gap,
                              input bit scramble, input int abort_at);
        int port;
        int cyc;
        int i;
        bit done;
        bit acc;
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] tbl_s [M];
        logic [M-1:0] en_s;
        port = route(t);
        dm = {16'($urandom), $urandom};
        sm = {16'($urandom), $urandom};
        tbl_s = tbl;
        en_s = en;
        @(posedge clk); #1;
        compare_q();
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac = dm;
        s_eth_src_mac = sm;
        s_eth_type = t;
        set_beat(0, nbeats);
        s_tvalid = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("hdr_ready", s_eth_hdr_ready, 1);
        check("early_stall", s_tready, 0);
        @(posedge clk); #1;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = {16'($urandom), $urandom};
        s_eth_src_mac = {16'($urandom), $urandom};
        s_eth_type = 16'($urandom);
        if (scramble) begin
            for (int k = 0; k < M; k++) tbl[k] = pick_type();
            en = M'($urandom);
        end
        if (port < 0) exp_drops = (exp_drops < CMAX) ? exp_drops + 1 : CMAX;
        cyc = 0;
        if (port >= 0) begin
            done = 1'b0;
            while (!done && cyc < 300) begin
                @(negedge clk);
                check("hdr_valid", m_eth_hdr_valid, onehot(port));
                check("hdr_dest_type", {m_eth_dest_mac, m_eth_type}, {dm, t});
                check("hdr_src", m_eth_src_mac, sm);
                check("hdr_stall", s_tready, 0);
                done = m_eth_hdr_ready[port];
                cyc++;
                if (!done) begin @(posedge clk); #1; end
            end
            if (!done) check("hdr_timeout", 0, 1);
            @(posedge clk); #1;
        end
        i = 0;
        while (i < nbeats && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (port < 0) begin
                check("drop_ready", s_tready, 1);
                check("drop_quiet", {m_eth_hdr_valid, m_tvalid}, 0);
                check("drop_busy", busy, 1);
            end else begin
                check("pass_tvalid", m_tvalid, s_tvalid ? onehot(port) : '0);
                check("pass_tready", s_tready, m_tready[port]);
            end
            acc = s_tvalid && s_tready;
            if (acc) begin
                if (port >= 0) exp_q.push_back(pack(port, s_tdata, s_tlast, s_tuser));
                i++;
            end
            if (i == nbeats || (abort_at > 0 && i == abort_at)) break;
            @(posedge clk); #1;
            if (acc) begin
                set_beat(i, nbeats);
                s_tvalid = ($urandom_range(99) >= gap);
            end else if (!s_tvalid) begin
                s_tvalid = ($urandom_range(99) >= gap);
            end
        end
        if (i < nbeats && !(abort_at > 0 && i == abort_at)) check("beat_timeout", i, nbeats);
        if (abort_at > 0) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            check("rst_quiet", {m_eth_hdr_valid, m_tvalid, s_eth_hdr_ready, s_tready}, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            exp_drops = 0;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_drop_count", drop_count, 0);
        end
        tbl = tbl_s;
        en = en_s;
    endtask

    initial begin
        rst = 1'b1;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = '0;
        m_eth_hdr_ready = '0;
        m_tready = '0;
        tbl[0] = 16'h0800;
        tbl[1] = 16'h0806;
        tbl[2] = 16'h88F7;
        tbl[3] = 16'h86DD;
        en = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_ready", s_eth_hdr_ready, 0);
        check("rst_valids", {m_eth_hdr_valid, m_tvalid, s_tready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_drop", drop_count, 0);
        check("post_rst_hdr_ready", s_eth_hdr_ready, 1);
        check("post_rst_quiet", {m_eth_hdr_valid, m_tvalid, s_tready}, 0);
        check("post_rst_fields", {m_eth_dest_mac, m_eth_type}, 0);
        check("post_rst_src", m_eth_src_mac, 0);

        rmode = 0; hdr_delay = 0;
        send_frame(16'h0800, 5, 0, 0, 0);
        send_frame(16'h1234, 64, 0, 0, 0);

        hdr_delay = 10; rmode = 2;
        send_frame(16'h0806, 12, 0, 0, 0);
        hdr_delay = 0;

        tbl[2] = 16'h0800; rmode = 1;
        send_frame(16'h0800, 4, 20, 0, 0);
        en[0] = 1'b0;
        send_frame(16'h0800, 4, 20, 0, 0);
        en = '1; tbl[2] = 16'h88F7; rmode = 0;

        send_frame(16'h0800, 1, 0, 0, 0);
        send_frame(16'h86DD, 1, 0, 0, 0);
        send_frame(16'h88F7, 2, 0, 0, 0);

        for (int n = 0; n < 270; n++) send_frame(16'h1234, 1, 0, 0, 0);

        send_frame(16'h0800, 8, 0, 0, 3);
        send_frame(16'h0800, 3, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < M; k++) tbl[k] = pick_type();
            en = M'($urandom);
            rmode = $urandom_range(2);
            hdr_delay = $urandom_range(3);
            send_frame(pick_type(), $urandom_range(1, 8), $urandom_range(30), 1'($urandom), 0);
        end

        @(posedge clk); #1;
        s_tvalid = 1'b0;
        compare_q();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
